// File: rtl/coin_pkg.sv
// coin_pkg: shared debounce state encoding and default debounce length for the coin input conditioner
package coin_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
  localparam int DEBOUNCE_DEFAULT = 500000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser plus press/release debounce FSM for one active-low key
module debounce_channel
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic held,
  output logic accept
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, p;
  deb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign p = ~s2_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_n;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // counter only runs in the two wait states and stops at LAST, so it never wraps
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE: if (p) begin
        state_d = PRESS_WAIT;
        cnt_d = CNT_W'(1);
      end
      PRESS_WAIT:
        if (!p) state_d = IDLE;
        else if (cnt_q == LAST) state_d = HELD;
        else cnt_d = cnt_q + CNT_W'(1);
      HELD: if (!p) begin
        state_d = RELEASE_WAIT;
        cnt_d = CNT_W'(1);
      end
      RELEASE_WAIT:
        if (p) state_d = HELD;
        else if (cnt_q == LAST) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    held = (state_q == HELD) || (state_q == RELEASE_WAIT);
    accept = (state_q == PRESS_WAIT) && p && (cnt_q == LAST);
  end
endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: turns two bouncing active-low coin keys into clean, mutually exclusive one-cycle pulses.
// Define COIN_CONDITIONER_LOCKOUT_EN to discard accepts for DEBOUNCE_CYCLES cycles after any coin pulse.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_100_n,
  input  logic key_500_n,
  output logic coin_100,
  output logic coin_500,
  output logic held_100,
  output logic held_500
);
  logic acc_100, acc_500, locked;
  logic coin_100_q, coin_100_d, coin_500_q, coin_500_d, pend_q, pend_d;
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_100 (
    .clk(clk), .reset(reset), .raw_n(key_100_n), .held(held_100), .accept(acc_100)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_500 (
    .clk(clk), .reset(reset), .raw_n(key_500_n), .held(held_500), .accept(acc_500)
  );
`ifdef COIN_CONDITIONER_LOCKOUT_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] lock_q, lock_d;
  assign locked = lock_q != '0;
  always_comb lock_d = (coin_100_d || coin_500_d) ? CNT_W'(DEBOUNCE_CYCLES) : locked ? lock_q - CNT_W'(1) : lock_q;
  always_ff @(posedge clk) begin
    if (!reset) lock_q <= '0;
    else lock_q <= lock_d;
  end
`else
  assign locked = 1'b0;
`endif
  // 500 wins a tie; the deferred 100 is replayed next cycle and ignores lockout
  always_comb begin
    coin_500_d = acc_500 & ~locked;
    coin_100_d = pend_q | (acc_100 & ~acc_500 & ~locked);
    pend_d = acc_100 & acc_500 & ~locked;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      coin_100_q <= 1'b0;
      coin_500_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      coin_100_q <= coin_100_d;
      coin_500_q <= coin_500_d;
      pend_q <= pend_d;
    end
  end
  assign coin_100 = coin_100_q;
  assign coin_500 = coin_500_q;
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: table, directed and random checks against a run-length debounce model
module tb_coin_input_conditioner;
  localparam int DC = 4;
  logic clk = 1'b0, reset = 1'b0, key_100_n = 1'b1, key_500_n = 1'b1;
  logic coin_100, coin_500, held_100, held_500;
  coin_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .key_100_n(key_100_n), .key_500_n(key_500_n),
    .coin_100(coin_100), .coin_500(coin_500), .held_100(held_100), .held_500(held_500)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit r;
    bit k1;
    bit k5;
    int n;
    int e100;
    int e500;
    bit h100;
    bit h500;
  } vec_t;
  vec_t tbl[12];
  int checks = 0, passed = 0;
  int cyc = 0, last_pulse = -1000;
  bit m_s1[2], m_s2[2], m_held[2], m_pend, m_c100, m_c500;
  int m_run[2];
  int n100, n500, first100, first500, edge_i;
  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b at cycle %0d", name, act, exp, cyc);
  endtask
  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
  endtask
  // model: a key level flips once it has differed from the debounced level for DC straight cycles
  task automatic model(bit r, bit k1, bit k5);
    bit acc[2];
    bit raw[2];
    bit locked;
    raw[0] = ~k1;
    raw[1] = ~k5;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_held[i] = 0; m_run[i] = 0;
      end
      m_pend = 0; m_c100 = 0; m_c500 = 0; last_pulse = -1000;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      acc[i] = 0;
      if (m_s2[i] != m_held[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_held[i] = m_s2[i];
          m_run[i] = 0;
          acc[i] = m_s2[i];
        end
      end else m_run[i] = 0;
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
`ifdef COIN_CONDITIONER_LOCKOUT_EN
    locked = (cyc - last_pulse) < DC;
`else
    locked = 0;
`endif
    m_c500 = acc[1] && !locked;
    m_c100 = m_pend || (acc[0] && !acc[1] && !locked);
    m_pend = acc[0] && acc[1] && !locked;
    if (m_c100 || m_c500) last_pulse = cyc + 1;
  endtask
  task automatic step(bit r, bit k1, bit k5);
    @(negedge clk);
    reset = r; key_100_n = k1; key_500_n = k5;
    @(posedge clk);
    model(r, k1, k5);
    #1;
    check("coin_100", coin_100, m_c100);
    check("coin_500", coin_500, m_c500);
    check("held_100", held_100, m_held[0]);
    check("held_500", held_500, m_held[1]);
    check("exclusive", coin_100 & coin_500, 1'b0);
    edge_i++;
    if (coin_100 === 1'b1) begin n100++; if (first100 < 0) first100 = edge_i; end
    if (coin_500 === 1'b1) begin n500++; if (first500 < 0) first500 = edge_i; end
    cyc++;
  endtask
  task automatic clr();
    n100 = 0; n500 = 0; first100 = -1; first500 = -1; edge_i = 0;
  endtask
  task automatic run(bit r, bit k1, bit k5, int n);
    for (int i = 0; i < n; i++) step(r, k1, k5);
  endtask
  initial begin
    tbl[0]  = '{0, 1, 1, 4, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 10, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 20, 0, 1, 0, 1};
    tbl[3]  = '{1, 1, 1, 10, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 20, 1, 0, 1, 0};
    tbl[5]  = '{1, 1, 1, 10, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 20, 1, 1, 1, 1};
    tbl[7]  = '{1, 1, 1, 10, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 20, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 1, 3, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 20, 1, 0, 1, 0};
    tbl[11] = '{1, 1, 1, 10, 0, 0, 0, 0};
    foreach (tbl[i]) begin
      clr();
      run(tbl[i].r, tbl[i].k1, tbl[i].k5, tbl[i].n);
      check_int($sformatf("tbl%0d_n100", i), n100, tbl[i].e100);
      check_int($sformatf("tbl%0d_n500", i), n500, tbl[i].e500);
      check($sformatf("tbl%0d_held100", i), held_100, tbl[i].h100);
      check($sformatf("tbl%0d_held500", i), held_500, tbl[i].h500);
    end
    clr();
    run(1, 1, 0, 20);
    check_int("clean_lat500", first500, 6);
    check_int("clean_n500", n500, 1);
    check_int("clean_n100", n100, 0);
    run(1, 1, 1, 10);
    clr();
    for (int i = 0; i < 5; i++) begin
      run(1, 0, 1, 2);
      run(1, 1, 1, 2);
    end
    check_int("bounce_none", n100, 0);
    clr();
    run(1, 0, 1, 20);
    check_int("bounce_lat100", first100, 6);
    check_int("bounce_n100", n100, 1);
    run(1, 1, 1, 10);
    clr();
    run(1, 0, 0, 20);
    check_int("simul_lat500", first500, 6);
    check_int("simul_lat100", first100, 7);
    check_int("simul_n100", n100, 1);
    check_int("simul_n500", n500, 1);
    run(1, 1, 1, 10);
    run(1, 0, 1, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      check("rst_coin100", coin_100, 1'b0);
      check("rst_held100", held_100, 1'b0);
    end
    clr();
    run(1, 0, 1, 20);
    check_int("rst_lat100", first100, 6);
    check_int("rst_n100", n100, 1);
    run(1, 1, 1, 10);
    clr();
    run(1, 0, 1, 50);
    run(1, 1, 1, 10);
    run(1, 0, 1, 10);
    check_int("repress_n100", n100, 2);
    run(1, 1, 1, 10);
    clr();
    run(1, 1, 0, 3);
    run(1, 0, 0, 20);
    check_int("lock_n500", n500, 1);
`ifdef COIN_CONDITIONER_LOCKOUT_EN
    check_int("lock_n100", n100, 0);
`else
    check_int("lock_n100", n100, 1);
    check_int("lock_lat100", first100, 9);
`endif
    run(1, 1, 1, 10);
    for (int s = 0; s < 600; s++)
      run($urandom_range(0, 49) != 0, 1'($urandom), 1'($urandom), $urandom_range(1, 9));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
